// File: rtl/soc_io.sv
// soc_io: memory-mapped LED register plus a buffered 8N1 UART transmitter.
// Register index = io_addr[3:2]: 0 LED, 1 TXDATA, 2 STATUS, 3 reserved.
//
// FIFO handshake: the push side offers a byte whenever TXDATA is written
// (valid = push_req); it is accepted when ready = !fifo_full || pop. An
// offer that is not accepted is dropped and sets the sticky overflow flag.
// The pop side (TX FSM) takes the head byte only when the FIFO is non-empty.
module soc_io #(
    parameter int N_LEDS         = 6,
    parameter int LED_ACTIVE_LOW = 1,
    parameter int CLKS_PER_BIT   = 234,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        io_addr,
    input  logic              io_wstrb,
    input  logic [31:0]       io_wdata,
    input  logic              io_rstrb,
    output logic [31:0]       io_rdata,
    output logic [N_LEDS-1:0] leds,
    output logic              txd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic [1:0]        reg_idx;
    logic [N_LEDS-1:0] led_q;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       level;
    logic              overflow;
    logic              fifo_full, fifo_empty;
    logic              push_req, push, pop;

    tx_state_t         state, state_n;
    tx_state_t         dbg_state;
    logic [CW-1:0]     baud_cnt, baud_n;
    logic [2:0]        bit_cnt, bit_n;
    logic [7:0]        shreg, shreg_n;
    logic              txd_q, txd_n;
    logic              baud_last, tx_busy;
    logic              unused_bits;

    assign reg_idx    = io_addr[3:2];
    assign fifo_full  = (level == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign push_req   = io_wstrb && (reg_idx == 2'd1);
    assign push       = push_req && (!fifo_full || pop);
    assign baud_last  = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign tx_busy    = (state != IDLE);
    assign dbg_state  = state;
    assign txd        = txd_q;
    assign leds       = (LED_ACTIVE_LOW != 0) ? ~led_q : led_q;
    assign unused_bits = ^{io_wdata, io_addr[1:0], dbg_state};

    // LED register write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            led_q <= '0;
        else if (io_wstrb && reg_idx == 2'd0)
            led_q <= io_wdata[N_LEDS-1:0];
    end

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= io_wdata[7:0];
    end

    // FIFO pointers, level and sticky overflow (a new drop wins over a clear).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
            if (push_req && !push)
                overflow <= 1'b1;
            else if (io_wstrb && reg_idx == 2'd2 && io_wdata[3])
                overflow <= 1'b0;
        end
    end

    // Registered read mux, sampling state from before this edge's updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            io_rdata <= '0;
        else if (io_rstrb) begin
            case (reg_idx)
                2'd0:    io_rdata <= 32'(led_q);
                2'd2:    io_rdata <= {16'h0, 8'(level), 4'h0,
                                      overflow, fifo_empty, fifo_full, tx_busy};
                default: io_rdata <= '0;
            endcase
        end
    end

    // TX FSM state register; txd is a flop loaded with the next line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            txd_q    <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            txd_q    <= txd_n;
        end
    end

    // TX FSM next state: start bit, 8 data bits LSB first, stop bit.
    always_comb begin
        state_n = state;
        baud_n  = baud_last ? '0 : baud_cnt + 1'b1;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        txd_n   = txd_q;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                txd_n  = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_n = fifo_mem[rd_ptr];
                    state_n = START;
                    txd_n   = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_n = DATA;
                    bit_n   = '0;
                    txd_n   = shreg[0];
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end else begin
                        bit_n   = bit_cnt + 1'b1;
                        shreg_n = {1'b0, shreg[7:1]};
                        txd_n   = shreg[1];
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_n = fifo_mem[rd_ptr];
                        state_n = START;
                        txd_n   = 1'b0;
                    end else begin
                        state_n = IDLE;
                        txd_n   = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_soc_io.sv
// Directed bench for soc_io: LED register, register map, UART framing,
// FIFO overflow and back-to-back frames, reset mid-frame.
module tb_soc_io;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int NL    = 6;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    io_addr;
    logic          io_wstrb;
    logic [31:0]   io_wdata;
    logic          io_rstrb;
    logic [31:0]   io_rdata, rdata_tp;
    logic [NL-1:0] leds, leds_tp;
    logic          txd, txd_tp;

    always #5 clk = ~clk;

    soc_io #(.N_LEDS(NL), .LED_ACTIVE_LOW(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset), .io_addr(io_addr), .io_wstrb(io_wstrb),
        .io_wdata(io_wdata), .io_rstrb(io_rstrb), .io_rdata(io_rdata),
        .leds(leds), .txd(txd));

    // True-polarity copy for the LED polarity check.
    soc_io #(.N_LEDS(NL), .LED_ACTIVE_LOW(0), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut_tp (
        .clk(clk), .reset(reset), .io_addr(io_addr), .io_wstrb(io_wstrb),
        .io_wdata(io_wdata), .io_rstrb(io_rstrb), .io_rdata(rdata_tp),
        .leds(leds_tp), .txd(txd_tp));

    // ---------------- scoreboard ----------------
    int         err_cnt = 0;
    int         chk_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        io_addr  = a;
        io_wdata = d;
        io_wstrb = 1'b1;
        @(posedge clk);
        #1;
        io_wstrb = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        io_addr  = a;
        io_rstrb = 1'b1;
        @(posedge clk);
        #1;
        io_rstrb = 1'b0;
        d = io_rdata;
    endtask

    // Samples txd every cycle for n contiguous frames and compares each
    // 40-cycle window against the frame built from the expected byte.
    task automatic capture_frames(input int n);
        logic [7:0]  b;
        logic [63:0] obs, expv;
        int          bi;
        for (int f = 0; f < n; f++) begin
            if (exp_q.size() == 0) begin
                chk("exp_q_empty", 64'd1, 64'd0);
                b = 8'h00;
            end else begin
                b = exp_q.pop_front();
            end
            obs  = '0;
            expv = '0;
            for (int w = 0; w < 10 * CPB; w++) begin
                bi = w / CPB;
                if (bi == 0)      expv[w] = 1'b0;
                else if (bi == 9) expv[w] = 1'b1;
                else              expv[w] = b[bi-1];
                @(posedge clk);
                #1;
                obs[w] = txd;
            end
            chk($sformatf("frame%0d_byte%02h", f, b), obs, expv);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rd;
    int          low_cnt;

    initial begin
        reset    = 1'b0;
        io_addr  = '0;
        io_wstrb = 1'b0;
        io_wdata = '0;
        io_rstrb = 1'b0;
        idle(3);
        chk("rst_txd", 64'(txd), 64'd1);
        chk("rst_leds", 64'(leds), 64'h3f);
        chk("rst_leds_tp", 64'(leds_tp), 64'h0);
        chk("rst_rdata", 64'(io_rdata), 64'h0);
        reset = 1'b1;
        idle(2);

        bus_read(4'h8, rd);
        chk("status_after_reset", 64'(rd), 64'h4);

        // LED register and polarity
        bus_write(4'h0, 32'h2A);
        bus_read(4'h0, rd);
        chk("led_read", 64'(rd), 64'h2A);
        chk("leds_pins", 64'(leds), 64'h15);
        chk("leds_tp_pins", 64'(leds_tp), 64'h2A);
        chk("led_read_tp", 64'(rdata_tp), 64'h2A);
        bus_write(4'h0, 32'hFFFF_FFFF);
        bus_read(4'h0, rd);
        chk("led_upper_zero", 64'(rd), 64'h3F);
        bus_write(4'h0, 32'h2A);

        // Reserved register and TXDATA reads
        bus_write(4'hC, 32'hFFFF_FFFF);
        bus_read(4'hC, rd);
        chk("reserved_read", 64'(rd), 64'h0);
        bus_read(4'h4, rd);
        chk("txdata_read", 64'(rd), 64'h0);
        bus_read(4'h0, rd);
        chk("led_after_reserved", 64'(rd), 64'h2A);
        bus_read(4'h8, rd);
        chk("status_still_empty", 64'(rd), 64'h4);

        // Single frame 0x55
        exp_q.push_back(8'h55);
        bus_write(4'h4, 32'h55);
        fork
            capture_frames(1);
            begin
                idle(9);
                bus_read(4'h8, rd);
                chk("status_busy_mid_frame", 64'(rd), 64'h5);
            end
        join
        idle(2);
        bus_read(4'h8, rd);
        chk("status_idle_after_frame", 64'(rd), 64'h4);
        chk("txd_idle", 64'(txd), 64'd1);
        chk("txd_tp_match", 64'(txd_tp), 64'd1);

        // Six consecutive writes: one popped, four buffered, one dropped
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        fork
            begin
                for (int i = 1; i <= 6; i++) bus_write(4'h4, 32'(i));
                bus_read(4'h8, rd);
                chk("status_full_overflow", 64'(rd), 64'h40B);
                bus_write(4'h8, 32'h8);
                bus_read(4'h8, rd);
                chk("status_overflow_cleared", 64'(rd), 64'h403);
            end
            begin
                @(posedge clk);
                #1;
                capture_frames(5);
            end
        join
        idle(2);
        bus_read(4'h8, rd);
        chk("status_after_burst", 64'(rd), 64'h4);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of data bit 3 of 0xA5
        bus_write(4'h4, 32'hA5);
        idle(17);
        chk("mid_frame_bit3", 64'(txd), 64'd0);
        reset = 1'b0;
        #1;
        chk("reset_txd_immediate", 64'(txd), 64'd1);
        chk("reset_leds", 64'(leds), 64'h3F);
        chk("reset_rdata", 64'(io_rdata), 64'h0);
        idle(2);
        reset = 1'b1;
        bus_read(4'h8, rd);
        chk("status_after_abort", 64'(rd), 64'h4);
        low_cnt = 0;
        for (int i = 0; i < 12 * CPB; i++) begin
            idle(1);
            if (txd == 1'b0) low_cnt++;
        end
        chk("no_residual_frame", 64'(low_cnt), 64'd0);
        bus_read(4'h0, rd);
        chk("led_after_abort", 64'(rd), 64'h0);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
